perc_train: RTL

PERC_TRAIN -- requirements
Module: perc_train

---
 rtl/perc_pkg.sv | 24 ++
 rtl/perc_train_if.sv | 27 ++
 rtl/perc_wsat.sv | 24 ++
 rtl/perc_train.sv | 115 +++++++++++
 4 files changed

// File: rtl/perc_pkg.sv
// rtl/perc_pkg.sv - shared FSM encoding and sizing/reset helpers for perc_train
package perc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC    = 3'd1,
    DECIDE = 3'd2,
    UPDATE = 3'd3,
    HOLD   = 3'd4
  } perc_state_t;

  // Reset weights form a walking one so every input starts with a distinct influence.
  function automatic int reset_weight(input int i, input int ww);
    return 1 << (i % ww);
  endfunction

  // Wide enough that WIDTH saturated weights can be summed without wrapping.
  function automatic int sum_width(input int ww, input int width);
    int w;
    w = ww + $clog2(width) + 1;
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/perc_train_if.sv
// rtl/perc_train_if.sv - sample/result handshake and status bundle for perc_train
interface perc_train_if #(
  parameter int WIDTH = 4,
  parameter int WW    = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    data_in;
  logic                label;
  logic                out_valid;
  logic                out_ready;
  logic                data_out;
  logic                err;
  logic [WIDTH*WW-1:0] weights;
  logic                clr_cnt;
  logic [7:0]          err_cnt;

  modport master (
    output in_valid, data_in, label, out_ready, clr_cnt,
    input  in_ready, out_valid, data_out, err, weights, err_cnt
  );

  modport slave (
    input  in_valid, data_in, label, out_ready, clr_cnt,
    output in_ready, out_valid, data_out, err, weights, err_cnt
  );
endinterface

// File: rtl/perc_wsat.sv
// rtl/perc_wsat.sv - WW-bit saturating increment/decrement cell for one weight
module perc_wsat #(
  parameter int WW = 4
) (
  input  logic [WW-1:0] w,
  input  logic          en,
  input  logic          up,
  output logic [WW-1:0] q
);

  localparam logic [WW-1:0] W_MAX = '1;

  always_comb begin
    q = w;
    if (en) begin
      if (up) begin
        if (w != W_MAX) q = w + 1'b1;
      end else begin
        if (w != '0) q = w - 1'b1;
      end
    end
  end

endmodule

// File: rtl/perc_train.sv
// rtl/perc_train.sv - single-neuron perceptron: bit-serial accumulate, decide, train
module perc_train
  import perc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WW     = 4,
  parameter int THRESH = 10
) (
  input logic         clk,
  input logic         rst_n,
  perc_train_if.slave bus
);

  localparam int SW = sum_width(WW, WIDTH);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [SW-1:0] TH = SW'(THRESH);

  perc_state_t   state;
  logic [WIDTH-1:0] x;
  logic             lbl;
  logic [SW-1:0]    sum;
  logic [IW-1:0]    idx;
  logic [WW-1:0]    w     [WIDTH];
  logic [WW-1:0]    w_nxt [WIDTH];
  logic             in_ready_r;
  logic             out_valid_r;
  logic             data_out_r;
  logic             err_r;
  logic [7:0]       cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_w
    perc_wsat #(.WW(WW)) u_wsat (
      .w  (w[i]),
      .en (x[i]),
      .up (lbl),
      .q  (w_nxt[i])
    );
    assign bus.weights[i*WW +: WW] = w[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      data_out_r  <= 1'b0;
      err_r       <= 1'b0;
      sum         <= '0;
      idx         <= '0;
      x           <= '0;
      lbl         <= 1'b0;
      for (int i = 0; i < WIDTH; i++) w[i] <= WW'(reset_weight(i, WW));
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x          <= bus.data_in;
            lbl        <= bus.label;
            sum        <= '0;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= ACC;
          end
        end
        ACC: begin
          if (x[idx]) sum <= sum + SW'(w[idx]);
          if (idx == IDX_LAST) state <= DECIDE;
          else                 idx   <= idx + 1'b1;
        end
        DECIDE: begin
          data_out_r <= (sum >= TH);
          err_r      <= (sum >= TH) != lbl;
          state      <= UPDATE;
        end
        UPDATE: begin
          // Only a misclassified sample moves the weights, toward its label.
          if (err_r) begin
            for (int i = 0; i < WIDTH; i++) w[i] <= w_nxt[i];
          end
          out_valid_r <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr_cnt) begin
      cnt <= '0;
    end else if (state == UPDATE && err_r && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.data_out  = data_out_r;
  assign bus.err       = err_r;
  assign bus.err_cnt   = cnt;

endmodule
